lcd_hd44780_responder: RTL and testbench

Clocked responder for the 4-bit HD44780 character-LCD bus, i.e. the panel end of the link our LCD display driver initiates. It oversamples E/RS/RW/DAT, latches nibbles on E falling edges, and assembles bytes once 4-bit mode is set. It executes the controller command subset the driver uses and keeps a 2x16 character image plus busy/read-back state. Used as a bench-side panel model and as an on-chip monitor that mirrors what the physical LCD shows.

---
 rtl/lcd_hd44780_responder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: panel-side model of the 4-bit HD44780 character-LCD bus.
// Oversamples the asynchronous bus, assembles bytes on E falling edges, executes
// the controller command subset and mirrors a 2x16 character image.
module lcd_hd44780_responder #(
    parameter int unsigned BUSY_CYCLES  = 40,
    parameter int unsigned CLEAR_CYCLES = 1600
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_e,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [3:0]   lcd_dat,
    output logic [3:0]   rd_dat,
    output logic         rd_oe,
    output logic [255:0] screen,
    output logic [6:0]   cursor,
    output logic         display_on,
    output logic         four_bit,
    output logic         two_line,
    output logic         busy,
    output logic         overrun
);

    localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES);
    localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES);

    // Address counter step with the HD44780 two-line wrap points.
    // Addresses outside both visible-line windows restart at 0x00.
    function automatic logic [6:0] cursor_step(input logic [6:0] cur, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (cur == 7'h27) begin
                nxt = 7'h40;
            end else if (cur == 7'h67) begin
                nxt = 7'h00;
            end else if ((cur < 7'h27) || ((cur >= 7'h40) && (cur < 7'h67))) begin
                nxt = cur + 7'h01;
            end else begin
                nxt = 7'h00;
            end
        end else begin
            if (cur == 7'h00) begin
                nxt = 7'h67;
            end else if (cur == 7'h40) begin
                nxt = 7'h27;
            end else if ((cur <= 7'h27) || ((cur > 7'h40) && (cur <= 7'h67))) begin
                nxt = cur - 7'h01;
            end else begin
                nxt = 7'h00;
            end
        end
        return nxt;
    endfunction

    // Address lands on one of the 32 displayed character slots.
    function automatic logic slot_visible(input logic [6:0] cur);
        return (cur[5:4] == 2'b00);
    endfunction

    // Synchroniser stages
    logic       e_s1_r, e_s2_r, e_s3_r;
    logic       rs_s1_r, rs_s2_r;
    logic       rw_s1_r, rw_s2_r;
    logic [3:0] dat_s1_r, dat_s2_r;

    // Architectural state
    logic [7:0]  chars_r [32];
    logic [6:0]  cursor_r;
    logic        id_r;
    logic        display_on_r;
    logic        four_bit_r;
    logic        two_line_r;
    logic [15:0] busy_cnt_r;
    logic        busy_r;
    logic        overrun_r;
    logic        phase_r;
    logic [3:0]  hi_nib_r;
    logic        rd_oe_r;
    logic [3:0]  rd_dat_r;

    // Decode / next-state signals
    logic        fall_s, rise_s, wr_fall_s, rd_fall_s, rd_rise_s;
    logic        byte_done_s, busy_eff_s, exec_s, ovr_s;
    logic [7:0]  byte_s;
    logic [6:0]  cursor_nxt_s;
    logic        id_nxt_s, disp_nxt_s, fb_nxt_s, tl_nxt_s;
    logic        clear_s, long_busy_s, wr_char_s;
    logic [4:0]  wr_slot_s;
    logic [15:0] cnt_nxt_s;
    logic        phase_nxt_s;
    logic [255:0] screen_s;

    // Two-flop synchronisers plus the previous E sample for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_s1_r   <= 1'b0;
            e_s2_r   <= 1'b0;
            e_s3_r   <= 1'b0;
            rs_s1_r  <= 1'b0;
            rs_s2_r  <= 1'b0;
            rw_s1_r  <= 1'b0;
            rw_s2_r  <= 1'b0;
            dat_s1_r <= 4'h0;
            dat_s2_r <= 4'h0;
        end else begin
            e_s1_r   <= lcd_e;
            e_s2_r   <= e_s1_r;
            e_s3_r   <= e_s2_r;
            rs_s1_r  <= lcd_rs;
            rs_s2_r  <= rs_s1_r;
            rw_s1_r  <= lcd_rw;
            rw_s2_r  <= rw_s1_r;
            dat_s1_r <= lcd_dat;
            dat_s2_r <= dat_s1_r;
        end
    end

    // Edge detection, byte assembly and busy gating.
    always_comb begin
        fall_s      = e_s3_r & ~e_s2_r;
        rise_s      = ~e_s3_r & e_s2_r;
        wr_fall_s   = fall_s & ~rw_s2_r;
        rd_fall_s   = fall_s & rw_s2_r;
        rd_rise_s   = rise_s & rw_s2_r;
        byte_done_s = wr_fall_s & (~four_bit_r | phase_r);
        byte_s      = four_bit_r ? {hi_nib_r, dat_s2_r} : {dat_s2_r, 4'h0};
        // A counter at 1 expires this cycle, so a byte landing now is accepted.
        busy_eff_s  = (busy_cnt_r > 16'd1);
        exec_s      = byte_done_s & ~busy_eff_s;
        ovr_s       = byte_done_s & busy_eff_s;
        wr_slot_s   = {cursor_r[6], cursor_r[3:0]};
    end

    // Instruction/data execution: next values of the controller registers.
    always_comb begin
        cursor_nxt_s = cursor_r;
        id_nxt_s     = id_r;
        disp_nxt_s   = display_on_r;
        fb_nxt_s     = four_bit_r;
        tl_nxt_s     = two_line_r;
        clear_s      = 1'b0;
        long_busy_s  = 1'b0;
        wr_char_s    = 1'b0;
        if (exec_s) begin
            if (rs_s2_r) begin
                wr_char_s    = slot_visible(cursor_r);
                cursor_nxt_s = cursor_step(cursor_r, id_r);
            end else begin
                casez (byte_s)
                    8'b1???????: cursor_nxt_s = byte_s[6:0];
                    8'b01??????: cursor_nxt_s = cursor_r;
                    8'b001?????: begin
                        fb_nxt_s = ~byte_s[4];
                        tl_nxt_s = byte_s[3];
                    end
                    8'b0001????: cursor_nxt_s = cursor_r;
                    8'b00001???: disp_nxt_s = byte_s[2];
                    8'b000001??: id_nxt_s = byte_s[1];
                    8'b0000001?: begin
                        cursor_nxt_s = 7'h00;
                        long_busy_s  = 1'b1;
                    end
                    8'b00000001: begin
                        cursor_nxt_s = 7'h00;
                        id_nxt_s     = 1'b1;
                        clear_s      = 1'b1;
                        long_busy_s  = 1'b1;
                    end
                    default: cursor_nxt_s = cursor_r;
                endcase
            end
        end else begin
            cursor_nxt_s = cursor_r;
        end
    end

    // Busy counter and nibble phase next-state.
    always_comb begin
        if (exec_s) begin
            cnt_nxt_s = long_busy_s ? CLEAR_LOAD : BUSY_LOAD;
        end else if (busy_cnt_r != 16'd0) begin
            cnt_nxt_s = busy_cnt_r - 16'd1;
        end else begin
            cnt_nxt_s = 16'd0;
        end
        if (wr_fall_s) begin
            phase_nxt_s = four_bit_r ? ~phase_r : 1'b0;
        end else if (rd_fall_s) begin
            phase_nxt_s = four_bit_r ? ~phase_r : phase_r;
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Controller registers, busy counter, overrun flag and nibble phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor_r     <= 7'h00;
            id_r         <= 1'b1;
            display_on_r <= 1'b0;
            four_bit_r   <= 1'b0;
            two_line_r   <= 1'b0;
            busy_cnt_r   <= 16'd0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
            phase_r      <= 1'b0;
            hi_nib_r     <= 4'h0;
        end else begin
            cursor_r     <= cursor_nxt_s;
            id_r         <= id_nxt_s;
            display_on_r <= disp_nxt_s;
            four_bit_r   <= fb_nxt_s;
            two_line_r   <= tl_nxt_s;
            busy_cnt_r   <= cnt_nxt_s;
            busy_r       <= (cnt_nxt_s != 16'd0);
            overrun_r    <= overrun_r | ovr_s;
            phase_r      <= phase_nxt_s;
            if (wr_fall_s && four_bit_r && !phase_r) begin
                hi_nib_r <= dat_s2_r;
            end
        end
    end

    // Character image: cleared to spaces, written by visible data bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                chars_r[i] <= 8'h20;
            end
        end else if (clear_s) begin
            for (int i = 0; i < 32; i++) begin
                chars_r[i] <= 8'h20;
            end
        end else if (wr_char_s) begin
            chars_r[wr_slot_s] <= byte_s;
        end
    end

    // Read-back: capture busy/address nibble on E rise, release on E fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_oe_r  <= 1'b0;
            rd_dat_r <= 4'h0;
        end else if (rd_rise_s) begin
            rd_oe_r <= 1'b1;
            if (rs_s2_r) begin
                rd_dat_r <= 4'h0;
            end else if (phase_r) begin
                rd_dat_r <= cursor_r[3:0];
            end else begin
                rd_dat_r <= {busy_r, cursor_r[6:4]};
            end
        end else if (fall_s) begin
            rd_oe_r <= 1'b0;
        end
    end

    // Flatten the slot array: line0 col0 in the top byte, line1 col15 at the bottom.
    always_comb begin
        screen_s = 256'h0;
        for (int i = 0; i < 32; i++) begin
            screen_s[255 - 8*i -: 8] = chars_r[i];
        end
    end

    assign screen     = screen_s;
    assign cursor     = cursor_r;
    assign display_on = display_on_r;
    assign four_bit   = four_bit_r;
    assign two_line   = two_line_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;
    assign rd_oe      = rd_oe_r;
    assign rd_dat     = rd_dat_r;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: directed self-checking bench for the HD44780 responder.
module tb_lcd_hd44780_responder;

    localparam logic [255:0] SPACES = {32{8'h20}};

    logic         clk;
    logic         rst;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [3:0]   lcd_dat;
    logic [3:0]   rd_dat;
    logic         rd_oe;
    logic [255:0] screen;
    logic [6:0]   cursor;
    logic         display_on;
    logic         four_bit;
    logic         two_line;
    logic         busy;
    logic         overrun;

    int           checks_total;
    int           checks_passed;
    logic         tb_four_bit;
    logic [255:0] exp_scr;
    logic [3:0]   rd_v;
    logic         oe_v;

    lcd_hd44780_responder #(
        .BUSY_CYCLES  (40),
        .CLEAR_CYCLES (1600)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_dat    (lcd_dat),
        .rd_dat     (rd_dat),
        .rd_oe      (rd_oe),
        .screen     (screen),
        .cursor     (cursor),
        .display_on (display_on),
        .four_bit   (four_bit),
        .two_line   (two_line),
        .busy       (busy),
        .overrun    (overrun)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_cycle(input logic rs_v, input logic rw_v, input logic [3:0] nib);
        @(negedge clk);
        lcd_rs  = rs_v;
        lcd_rw  = rw_v;
        lcd_dat = nib;
        wait_clk(2);
        lcd_e = 1'b1;
        wait_clk(4);
        lcd_e = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_byte(input logic rs_v, input logic [7:0] b, input int gap);
        if (tb_four_bit) begin
            bus_cycle(rs_v, 1'b0, b[7:4]);
            bus_cycle(rs_v, 1'b0, b[3:0]);
        end else begin
            bus_cycle(rs_v, 1'b0, b[7:4]);
        end
        wait_clk(gap);
    endtask

    task automatic read_nib(output logic [3:0] d, output logic oe);
        @(negedge clk);
        lcd_rs = 1'b0;
        lcd_rw = 1'b1;
        wait_clk(2);
        lcd_e = 1'b1;
        wait_clk(4);
        d  = rd_dat;
        oe = rd_oe;
        lcd_e = 1'b0;
        wait_clk(4);
        lcd_rw = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check_val({pfx, "_screen"}, screen, SPACES);
        check_val({pfx, "_cursor"}, {249'h0, cursor}, 256'h0);
        check_val({pfx, "_disp"}, {255'h0, display_on}, 256'h0);
        check_val({pfx, "_fourbit"}, {255'h0, four_bit}, 256'h0);
        check_val({pfx, "_twoline"}, {255'h0, two_line}, 256'h0);
        check_val({pfx, "_busy"}, {255'h0, busy}, 256'h0);
        check_val({pfx, "_overrun"}, {255'h0, overrun}, 256'h0);
        check_val({pfx, "_rdoe"}, {255'h0, rd_oe}, 256'h0);
        check_val({pfx, "_rddat"}, {252'h0, rd_dat}, 256'h0);
    endtask

    task automatic lcd_init();
        tb_four_bit = 1'b0;
        send_byte(1'b0, 8'h30, 50);
        send_byte(1'b0, 8'h30, 50);
        send_byte(1'b0, 8'h30, 50);
        send_byte(1'b0, 8'h20, 50);
        check_val("init_fourbit_sw", {255'h0, four_bit}, 256'h1);
        check_val("init_twoline_sw", {255'h0, two_line}, 256'h0);
        tb_four_bit = 1'b1;
        send_byte(1'b0, 8'h28, 50);
        send_byte(1'b0, 8'h0C, 50);
        send_byte(1'b0, 8'h06, 50);
        send_byte(1'b0, 8'h01, 1700);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        tb_four_bit   = 1'b0;
        rst     = 1'b0;
        lcd_e   = 1'b0;
        lcd_rs  = 1'b0;
        lcd_rw  = 1'b0;
        lcd_dat = 4'h0;
        wait_clk(3);
        check_reset("rst");
        rst = 1'b1;
        wait_clk(3);
        check_val("rst_rel_screen", screen, SPACES);

        // Power-on initialisation sequence
        lcd_init();
        check_val("init_fourbit", {255'h0, four_bit}, 256'h1);
        check_val("init_twoline", {255'h0, two_line}, 256'h1);
        check_val("init_disp", {255'h0, display_on}, 256'h1);
        check_val("init_screen", screen, SPACES);
        check_val("init_cursor", {249'h0, cursor}, 256'h0);
        check_val("init_overrun", {255'h0, overrun}, 256'h0);
        check_val("init_busy", {255'h0, busy}, 256'h0);

        // Text on line 0
        send_byte(1'b1, 8'h48, 50);
        send_byte(1'b1, 8'h49, 50);
        exp_scr = SPACES;
        exp_scr[255:240] = 16'h4849;
        check_val("text_chars", {240'h0, screen[255:240]}, 256'h4849);
        check_val("text_screen", screen, exp_scr);
        check_val("text_cursor", {249'h0, cursor}, 256'h2);

        // Line 1 end, invisible addresses and the 0x27 -> 0x40 wrap
        send_byte(1'b0, 8'hCF, 50);
        send_byte(1'b1, 8'h41, 50);
        send_byte(1'b1, 8'h42, 50);
        exp_scr[7:0] = 8'h41;
        check_val("l2_last", {248'h0, screen[7:0]}, 256'h41);
        check_val("l2_cursor", {249'h0, cursor}, 256'h51);
        send_byte(1'b0, 8'hA7, 50);
        check_val("wrap_setaddr", {249'h0, cursor}, 256'h27);
        send_byte(1'b1, 8'h5A, 50);
        check_val("wrap_cursor", {249'h0, cursor}, 256'h40);
        check_val("wrap_screen", screen, exp_scr);

        // Busy read right after clear, then after it expires
        send_byte(1'b0, 8'h01, 0);
        read_nib(rd_v, oe_v);
        check_val("bread_hi", {252'h0, rd_v}, 256'h8);
        check_val("bread_oe", {255'h0, oe_v}, 256'h1);
        read_nib(rd_v, oe_v);
        check_val("bread_lo", {252'h0, rd_v}, 256'h0);
        check_val("bread_oe_drop", {255'h0, rd_oe}, 256'h0);
        check_val("clear_screen", screen, SPACES);
        wait_clk(1700);
        read_nib(rd_v, oe_v);
        check_val("idle_hi", {252'h0, rd_v}, 256'h0);
        read_nib(rd_v, oe_v);
        check_val("idle_lo", {252'h0, rd_v}, 256'h0);

        // Overrun: second data byte completes while the first is still busy
        send_byte(1'b1, 8'h41, 0);
        send_byte(1'b1, 8'h42, 50);
        exp_scr = SPACES;
        exp_scr[255:248] = 8'h41;
        check_val("ovr_flag", {255'h0, overrun}, 256'h1);
        check_val("ovr_cursor", {249'h0, cursor}, 256'h1);
        check_val("ovr_screen", screen, exp_scr);

        // Decrement mode and its wrap points
        send_byte(1'b0, 8'h04, 50);
        send_byte(1'b0, 8'h80, 50);
        send_byte(1'b1, 8'h44, 50);
        exp_scr[255:248] = 8'h44;
        check_val("dec_wrap0", {249'h0, cursor}, 256'h67);
        send_byte(1'b0, 8'hC0, 50);
        send_byte(1'b1, 8'h45, 50);
        exp_scr[127:120] = 8'h45;
        check_val("dec_wrap40", {249'h0, cursor}, 256'h27);
        check_val("dec_screen", screen, exp_scr);
        check_val("ovr_sticky", {255'h0, overrun}, 256'h1);

        // Reset in the middle of a 4-bit byte
        bus_cycle(1'b1, 1'b0, 4'h4);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_clk(2);
        check_reset("midrst");
        lcd_init();
        check_val("reinit_screen", screen, SPACES);
        check_val("reinit_cursor", {249'h0, cursor}, 256'h0);
        check_val("reinit_fourbit", {255'h0, four_bit}, 256'h1);
        check_val("reinit_disp", {255'h0, display_on}, 256'h1);
        check_val("reinit_overrun", {255'h0, overrun}, 256'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
